// File: rtl/pseudo_color_pkg.sv
// Shared constants for the gray-to-false-colour stage: segment codes and ready-count terminal value.
package pseudo_color_pkg;

  localparam int SEG_W = 2;

  localparam logic [SEG_W-1:0] SEG_B2C = 2'd0;
  localparam logic [SEG_W-1:0] SEG_C2G = 2'd1;
  localparam logic [SEG_W-1:0] SEG_G2Y = 2'd2;
  localparam logic [SEG_W-1:0] SEG_Y2R = 2'd3;

  localparam logic [1:0] READY_CNT = 2'd3;

endpackage

// File: rtl/pseudo_color_if.sv
// Stream bus for pseudo_color; in_bypass exists only when PSEUDO_COLOR_BYPASS_EN is defined.
interface pseudo_color_if #(parameter int color_width = 8);

  logic                     in_enable;
  logic [color_width-1:0]   in_data;
`ifdef PSEUDO_COLOR_BYPASS_EN
  logic                     in_bypass;
`endif
  logic                     out_ready;
  logic [3*color_width-1:0] out_data;

`ifdef PSEUDO_COLOR_BYPASS_EN
  modport master (output in_enable, in_data, in_bypass, input out_ready, out_data);
  modport slave  (input in_enable, in_data, in_bypass, output out_ready, out_data);
`else
  modport master (output in_enable, in_data, input out_ready, out_data);
  modport slave  (input in_enable, in_data, output out_ready, out_data);
`endif

endinterface

// File: rtl/pseudo_color_seg_map.sv
// Combinational 4-segment rainbow map: (seg, ramp, max) -> packed {R,G,B}.
module pseudo_color_seg_map
  import pseudo_color_pkg::*;
#(
  parameter int cw = 8
) (
  input  logic [SEG_W-1:0] seg,
  input  logic [cw-1:0]    ramp,
  input  logic [cw-1:0]    max_val,
  output logic [3*cw-1:0]  rgb
);

  logic [cw-1:0] red_s;
  logic [cw-1:0] grn_s;
  logic [cw-1:0] blu_s;

  // Blue -> cyan -> green -> yellow -> red; ramp never exceeds max_val-3 so the subtractions stay positive
  always_comb begin
    red_s = {cw{1'b0}};
    grn_s = {cw{1'b0}};
    blu_s = {cw{1'b0}};
    case (seg)
      SEG_B2C: begin
        grn_s = ramp;
        blu_s = max_val;
      end
      SEG_C2G: begin
        grn_s = max_val;
        blu_s = max_val - ramp;
      end
      SEG_G2Y: begin
        red_s = ramp;
        grn_s = max_val;
      end
      SEG_Y2R: begin
        red_s = max_val;
        grn_s = max_val - ramp;
      end
      default: begin
        red_s = {cw{1'b0}};
        grn_s = {cw{1'b0}};
        blu_s = {cw{1'b0}};
      end
    endcase
    rgb = {red_s, grn_s, blu_s};
  end

endmodule

// File: rtl/pseudo_color.sv
// Gray -> RGB false-colour stream, three register stages (S1, S2, OUT), fixed 3-edge latency.
// Optional PSEUDO_COLOR_BYPASS_EN adds in_bypass, which replicates gray onto all three channels.
module pseudo_color
  import pseudo_color_pkg::*;
#(
  parameter int work_mode   = 0,
  parameter int color_width = 8
) (
  input  logic           clk,
  input  logic           rst,
  pseudo_color_if.slave  bus
);

  localparam int CW = color_width;
  localparam logic [CW-1:0] MAX_VAL = {CW{1'b1}};

  logic [CW-1:0]    s1_g_r;
  logic             en_prev_r;
  logic             s1_load_s;
  logic [SEG_W-1:0] s2_seg_r;
  logic [CW-1:0]    s2_ramp_r;
  logic [3*CW-1:0]  map_s;
  logic [3*CW-1:0]  out_r;
  logic [1:0]       cnt_r;
`ifdef PSEUDO_COLOR_BYPASS_EN
  logic             s1_byp_r;
  logic             s2_byp_r;
  logic [CW-1:0]    s2_g_r;
`endif

  // In work_mode 1, S1 only loads on the cycle in_enable first goes high
  always_comb begin
    if (work_mode == 0) begin
      s1_load_s = 1'b1;
    end else begin
      s1_load_s = ~en_prev_r;
    end
  end

  pseudo_color_seg_map #(.cw(CW)) u_seg_map (
    .seg     (s2_seg_r),
    .ramp    (s2_ramp_r),
    .max_val (MAX_VAL),
    .rgb     (map_s)
  );

  // Pipeline, enable history and ready counter; a low in_enable flushes exactly like reset
  always_ff @(posedge clk) begin
    if (rst || !bus.in_enable) begin
      s1_g_r    <= {CW{1'b0}};
      en_prev_r <= 1'b0;
      s2_seg_r  <= {SEG_W{1'b0}};
      s2_ramp_r <= {CW{1'b0}};
      out_r     <= {(3*CW){1'b0}};
      cnt_r     <= 2'd0;
`ifdef PSEUDO_COLOR_BYPASS_EN
      s1_byp_r  <= 1'b0;
      s2_byp_r  <= 1'b0;
      s2_g_r    <= {CW{1'b0}};
`endif
    end else begin
      en_prev_r <= 1'b1;
      if (s1_load_s) begin
        s1_g_r   <= bus.in_data;
`ifdef PSEUDO_COLOR_BYPASS_EN
        s1_byp_r <= bus.in_bypass;
`endif
      end
      s2_seg_r  <= s1_g_r[CW-1 -: SEG_W];
      s2_ramp_r <= {s1_g_r[CW-3:0], 2'b00};
`ifdef PSEUDO_COLOR_BYPASS_EN
      s2_byp_r  <= s1_byp_r;
      s2_g_r    <= s1_g_r;
      out_r     <= s2_byp_r ? {s2_g_r, s2_g_r, s2_g_r} : map_s;
`else
      out_r     <= map_s;
`endif
      if (cnt_r != READY_CNT) begin
        cnt_r <= cnt_r + 2'd1;
      end
    end
  end

  assign bus.out_ready = (cnt_r == READY_CNT);
  assign bus.out_data  = bus.out_ready ? out_r : {(3*CW){1'b0}};

endmodule

// File: tb/tb_pseudo_color.sv
// Directed self-checking bench for pseudo_color (cw=8): one work_mode 0 and one work_mode 1 instance.
// Define PSEUDO_COLOR_BYPASS_EN to also exercise the gray bypass.
module tb_pseudo_color;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pseudo_color_if #(.color_width(8)) if0 ();
  pseudo_color_if #(.color_width(8)) if1 ();

  pseudo_color #(.work_mode(0), .color_width(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  pseudo_color #(.work_mode(1), .color_width(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%06h, expected 0x%06h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  g_vec   [6];
  logic [23:0] rgb_vec [6];

  initial begin
    n_cmp = 0;
    n_err = 0;
    g_vec   = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd255, 8'd100};
    rgb_vec = '{24'h0000FF, 24'h00FFFF, 24'h00FF00, 24'hFFFF00, 24'hFF0300, 24'h00FF6F};

    rst           = 1'b1;
    if0.in_enable = 1'b1;
    if0.in_data   = 8'd0;
    if1.in_enable = 1'b0;
    if1.in_data   = 8'd0;
`ifdef PSEUDO_COLOR_BYPASS_EN
    if0.in_bypass = 1'b0;
    if1.in_bypass = 1'b0;
`endif

    // Reset held two cycles with enable high
    tick();
    tick();
    check_eq("rst_ready", {31'd0, if0.out_ready}, 32'd0);
    check_eq("rst_data", {8'd0, if0.out_data}, 32'd0);
    rst = 1'b0;

    // Back-to-back map points, each appearing three edges after it is presented
    for (int i = 0; i < 8; i++) begin
      if0.in_data = g_vec[(i < 6) ? i : 5];
      tick();
      if (i < 2) begin
        check_eq($sformatf("ready_low_%0d", i), {31'd0, if0.out_ready}, 32'd0);
      end else begin
        check_eq($sformatf("map_ready_%0d", i - 2), {31'd0, if0.out_ready}, 32'd1);
        check_eq($sformatf("map_g%0d", g_vec[i - 2]), {8'd0, if0.out_data}, {8'd0, rgb_vec[i - 2]});
      end
    end

    // One-cycle flush mid-stream, then restart with a new pixel
    if0.in_enable = 1'b0;
    tick();
    check_eq("flush_ready", {31'd0, if0.out_ready}, 32'd0);
    check_eq("flush_data", {8'd0, if0.out_data}, 32'd0);
    if0.in_enable = 1'b1;
    if0.in_data   = 8'd64;
    tick();
    check_eq("reen_ready1", {31'd0, if0.out_ready}, 32'd0);
    check_eq("reen_data1", {8'd0, if0.out_data}, 32'd0);
    tick();
    check_eq("reen_ready2", {31'd0, if0.out_ready}, 32'd0);
    tick();
    check_eq("reen_ready3", {31'd0, if0.out_ready}, 32'd1);
    check_eq("reen_data3", {8'd0, if0.out_data}, 32'h0000FFFF);

    // Reset while streaming
    rst = 1'b1;
    tick();
    check_eq("midrst_ready", {31'd0, if0.out_ready}, 32'd0);
    rst = 1'b0;

`ifdef PSEUDO_COLOR_BYPASS_EN
    if0.in_data   = 8'd100;
    if0.in_bypass = 1'b1;
    tick();
    if0.in_bypass = 1'b0;
    tick();
    tick();
    check_eq("byp_on", {8'd0, if0.out_data}, 32'h00646464);
    tick();
    check_eq("byp_off", {8'd0, if0.out_data}, 32'h0000FF6F);
`endif

    // work_mode 1: sample on the enable rising cycle, then hold
    if1.in_data   = 8'd128;
    if1.in_enable = 1'b1;
    tick();
    if1.in_data = 8'd0;
    tick();
    check_eq("wm1_ready2", {31'd0, if1.out_ready}, 32'd0);
    tick();
    check_eq("wm1_ready3", {31'd0, if1.out_ready}, 32'd1);
    check_eq("wm1_data3", {8'd0, if1.out_data}, 32'h0000FF00);
    tick();
    tick();
    tick();
    check_eq("wm1_hold", {8'd0, if1.out_data}, 32'h0000FF00);
    if1.in_enable = 1'b0;
    tick();
    check_eq("wm1_flush", {31'd0, if1.out_ready}, 32'd0);
    if1.in_enable = 1'b1;
    tick();
    tick();
    tick();
    check_eq("wm1_resample", {8'd0, if1.out_data}, 32'h000000FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
